// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: the flags word and the writeback entry.
package aluPkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flagsType;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  dest;
      logic        writeReg;
   } wbEntryType;

   localparam int WB_DEPTH = 2;

   function automatic flagsType deriveFlags(input logic [31:0] result,
                                            input logic        carry,
                                            input logic        overflow);
      flagsType f;
      f.n = result[31];
      f.z = (result == 32'd0);
      f.c = carry;
      f.v = overflow;
      return f;
   endfunction

endpackage

// File: rtl/alu_result_stage_wb_fifo.sv
// Two-entry in-order buffer of writeback entries; head output holds its last value when empty.
module wb_fifo
   import aluPkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  wbEntryType pushEntry,
   input  logic       pop,
   output logic [1:0] count,
   output wbEntryType headEntry
);

   wbEntryType mem [2];
   wbEntryType holdQ;
   logic       head;
   logic       tail;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         holdQ  <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
      end else begin
         holdQ <= headEntry;
         if (push) begin
            mem[tail] <= pushEntry;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // After the last pop the head pointer lands on a stale slot, so replay the previous output instead.
   assign headEntry = (count != 2'd0) ? mem[head] : holdQ;

endmodule

// File: rtl/alu_result_stage.sv
// ALU back end: captures the registered result, updates N/Z/C/V, forwards carry and queues writebacks.
module alu_result_stage
   import aluPkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        aluDone,
   input  logic [31:0] aluResult,
   input  logic        aluCarry,
   input  logic        aluOverflow,
   input  logic [4:0]  destReg,
   input  logic        writeReg,
   input  logic        writeFlags,
   input  logic        flagsLoad,
   input  logic [3:0]  flagsIn,
   output logic        stageReady,
   output logic        carryFlag,
   output logic [3:0]  flags,
   output logic        wbValid,
   input  logic        wbReady,
   output logic [31:0] wbData,
   output logic [4:0]  wbDest,
   output logic        wbWriteReg
);

   localparam logic [2:0] DEPTH_LIMIT = 3'(DEPTH);

   logic       pending;
   logic [4:0] pendDest;
   logic       pendWriteReg;
   logic       pendWriteFlags;
   flagsType   flagsQ;
   logic [1:0] count;
   logic       capture;
   logic       pop;
   wbEntryType pushEntry;
   wbEntryType headEntry;

   // Conservative: a same-cycle pop is ignored so a push never meets a full buffer.
   assign stageReady = ({1'b0, count} + {2'b00, pending}) < DEPTH_LIMIT;
   assign capture    = aluDone & stageReady;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending        <= 1'b0;
         pendDest       <= 5'd0;
         pendWriteReg   <= 1'b0;
         pendWriteFlags <= 1'b0;
      end else begin
         pending <= capture;
         if (capture) begin
            pendDest       <= destReg;
            pendWriteReg   <= writeReg;
            pendWriteFlags <= writeFlags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flagsQ <= '0;
      end else if (flagsLoad) begin
         flagsQ <= flagsType'(flagsIn);
      end else if (pending && pendWriteFlags) begin
         flagsQ <= deriveFlags(aluResult, aluCarry, aluOverflow);
      end
   end

   assign flags     = flagsQ;
   assign carryFlag = (pending && pendWriteFlags) ? aluCarry : flagsQ.c;

   assign pushEntry.data     = aluResult;
   assign pushEntry.dest     = pendDest;
   assign pushEntry.writeReg = pendWriteReg;

   assign wbValid = (count != 2'd0);
   assign pop     = wbValid & wbReady;

   wb_fifo u_wb_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pending),
      .pushEntry (pushEntry),
      .pop       (pop),
      .count     (count),
      .headEntry (headEntry)
   );

   assign wbData     = headEntry.data;
   assign wbDest     = headEntry.dest;
   assign wbWriteReg = headEntry.writeReg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        aluDone;
   logic [31:0] aluResult;
   logic        aluCarry;
   logic        aluOverflow;
   logic [4:0]  destReg;
   logic        writeReg;
   logic        writeFlags;
   logic        flagsLoad;
   logic [3:0]  flagsIn;
   logic        stageReady;
   logic        carryFlag;
   logic [3:0]  flags;
   logic        wbValid;
   logic        wbReady;
   logic [31:0] wbData;
   logic [4:0]  wbDest;
   logic        wbWriteReg;

   always #5 clk = ~clk;

   alu_result_stage #(.DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .aluDone     (aluDone),
      .aluResult   (aluResult),
      .aluCarry    (aluCarry),
      .aluOverflow (aluOverflow),
      .destReg     (destReg),
      .writeReg    (writeReg),
      .writeFlags  (writeFlags),
      .flagsLoad   (flagsLoad),
      .flagsIn     (flagsIn),
      .stageReady  (stageReady),
      .carryFlag   (carryFlag),
      .flags       (flags),
      .wbValid     (wbValid),
      .wbReady     (wbReady),
      .wbData      (wbData),
      .wbDest      (wbDest),
      .wbWriteReg  (wbWriteReg)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic [4:0]  dst;
      logic        wr;
   } ent_t;

   ent_t       q[$];
   ent_t       lastOut;
   bit         mPend;
   bit         mPendWr;
   bit         mPendWf;
   logic [4:0] mPendDest;
   logic [3:0] mFlags;
   bit         checkEn = 0;

   function automatic ent_t curOut();
      if (q.size() > 0) return q[0];
      return lastOut;
   endfunction

   // Advance the model by one clock using the inputs present at this edge.
   task automatic modelStep();
      ent_t o;
      bit   rdy;
      o = curOut();
      if (reset) begin
         q.delete();
         mPend = 0; mPendWr = 0; mPendWf = 0; mPendDest = '0;
         mFlags = '0;
         lastOut = '{d: 32'd0, dst: 5'd0, wr: 1'b0};
      end else begin
         rdy = (q.size() + int'(mPend)) < 2;
         lastOut = o;
         if (q.size() > 0 && wbReady) void'(q.pop_front());
         if (flagsLoad)
            mFlags = flagsIn;
         else if (mPend && mPendWf)
            mFlags = {aluResult[31], aluResult == 32'd0, aluCarry, aluOverflow};
         if (mPend) q.push_back('{d: aluResult, dst: mPendDest, wr: mPendWr});
         if (aluDone && rdy) begin
            mPend = 1; mPendDest = destReg; mPendWr = writeReg; mPendWf = writeFlags;
         end else begin
            mPend = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      ent_t o;
      if (checkEn) begin
         o = curOut();
         check("wbValid",    {31'd0, wbValid},    {31'd0, q.size() > 0});
         check("stageReady", {31'd0, stageReady}, {31'd0, (q.size() + int'(mPend)) < 2});
         check("carryFlag",  {31'd0, carryFlag},
               {31'd0, (mPend && mPendWf) ? aluCarry : mFlags[1]});
         check("flags",      {28'd0, flags},      {28'd0, mFlags});
         check("wbData",     wbData,              o.d);
         check("wbDest",     {27'd0, wbDest},     {27'd0, o.dst});
         check("wbWriteReg", {31'd0, wbWriteReg}, {31'd0, o.wr});
         check("queueBound", {31'd0, q.size() <= 2}, 32'd1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1; aluDone = 1'b0; flagsLoad = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; aluDone = 0; aluResult = '0; aluCarry = 0; aluOverflow = 0;
      destReg = '0; writeReg = 0; writeFlags = 0; flagsLoad = 0; flagsIn = '0; wbReady = 0;
      cyc();
      checkEn = 1;
      @(negedge clk);
      check("rst_wbValid",    {31'd0, wbValid},    32'd0);
      check("rst_stageReady", {31'd0, stageReady}, 32'd1);
      check("rst_flags",      {28'd0, flags},      32'd0);
      check("rst_carryFlag",  {31'd0, carryFlag},  32'd0);
      check("rst_wbData",     wbData,              32'd0);

      // Basic add producing zero with carry.
      cyc();
      reset = 0; aluDone = 1; destReg = 5'd3; writeReg = 1; writeFlags = 1;
      cyc();
      aluDone = 0; aluResult = 32'd0; aluCarry = 1; aluOverflow = 0;
      @(negedge clk);
      check("fwd_carryFlag", {31'd0, carryFlag}, 32'd1);
      check("fwd_flagsC",    {31'd0, flags[1]},  32'd0);
      cyc();
      @(negedge clk);
      check("add_flags",   {28'd0, flags},   32'h6);
      check("add_wbValid", {31'd0, wbValid}, 32'd1);
      check("add_wbData",  wbData,           32'd0);
      check("add_wbDest",  {27'd0, wbDest},  32'd3);

      // Back-pressure and in-order drain.
      doReset();
      wbReady = 0; aluDone = 1; destReg = 5'd1; writeReg = 1; writeFlags = 0;
      cyc();
      aluDone = 1; destReg = 5'd2; aluResult = 32'h11;
      @(negedge clk);
      check("bp_ready_b", {31'd0, stageReady}, 32'd1);
      cyc();
      aluDone = 1; destReg = 5'd7; aluResult = 32'h22;
      @(negedge clk);
      check("bp_ready_c", {31'd0, stageReady}, 32'd0);
      cyc();
      aluDone = 0; aluResult = 32'h33;
      @(negedge clk);
      check("bp_ready_d", {31'd0, stageReady}, 32'd0);
      check("bp_head_d",  wbData,              32'h11);
      cyc();
      wbReady = 1;
      @(negedge clk);
      check("bp_head_e",  wbData,              32'h11);
      check("bp_dest_e",  {27'd0, wbDest},     32'd1);
      cyc();
      @(negedge clk);
      check("bp_head_f",  wbData,              32'h22);
      check("bp_dest_f",  {27'd0, wbDest},     32'd2);
      check("bp_ready_f", {31'd0, stageReady}, 32'd1);
      cyc();
      @(negedge clk);
      check("bp_empty_g", {31'd0, wbValid},    32'd0);
      check("bp_hold_g",  wbData,              32'h22);

      // External flags restore beats a flag-writing push.
      aluDone = 1; writeFlags = 1; destReg = 5'd4;
      cyc();
      aluDone = 0; flagsLoad = 1; flagsIn = 4'b1001; aluResult = 32'd0; aluCarry = 1; aluOverflow = 0;
      cyc();
      flagsLoad = 0;
      @(negedge clk);
      check("fl_flags", {28'd0, flags}, 32'h9);

      // A push that does not write flags.
      aluDone = 1; writeFlags = 0; writeReg = 1; destReg = 5'd9;
      cyc();
      aluDone = 0; aluResult = 32'h8000_0000; aluCarry = 1; aluOverflow = 1;
      cyc();
      @(negedge clk);
      check("nf_flags",   {28'd0, flags},   32'h9);
      check("nf_wbValid", {31'd0, wbValid}, 32'd1);
      check("nf_wbData",  wbData,           32'h8000_0000);
      check("nf_wbDest",  {27'd0, wbDest},  32'd9);

      // Reset with a buffered entry and a capture in flight.
      wbReady = 0; aluDone = 1; writeFlags = 1; destReg = 5'd5;
      cyc();
      aluDone = 1; aluResult = 32'd5;
      cyc();
      aluDone = 0; aluResult = 32'd6; reset = 1;
      cyc();
      reset = 0;
      @(negedge clk);
      check("rm_wbValid",    {31'd0, wbValid},    32'd0);
      check("rm_flags",      {28'd0, flags},      32'd0);
      check("rm_stageReady", {31'd0, stageReady}, 32'd1);
      cyc();
      cyc();
      @(negedge clk);
      check("rm_noStale", {31'd0, wbValid}, 32'd0);

      // Randomized traffic, including occasional protocol-violating aluDone and resets.
      for (int i = 0; i < 3000; i++) begin
         cyc();
         reset       = ($urandom_range(0, 199) == 0);
         aluDone     = $urandom_range(0, 1);
         aluResult   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         aluCarry    = $urandom_range(0, 1);
         aluOverflow = $urandom_range(0, 1);
         destReg     = 5'($urandom);
         writeReg    = $urandom_range(0, 1);
         writeFlags  = $urandom_range(0, 1);
         flagsLoad   = ($urandom_range(0, 9) == 0);
         flagsIn     = 4'($urandom);
         wbReady     = ($urandom_range(0, 9) < 6);
      end
      cyc();
      @(negedge clk);
      checkEn = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
